// File: rtl/ahbl_arbiter_2to1.sv
// Two-manager to one-subordinate AHB-lite arbiter. Uncontested address phases are
// forwarded combinationally; losing ones are buffered per port and replayed later.
module ahbl_arbiter_2to1 #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              src0_hready_resp,
    input  logic              src0_hready,
    output logic              src0_hresp,
    input  logic [W_ADDR-1:0] src0_haddr,
    input  logic              src0_hwrite,
    input  logic [1:0]        src0_htrans,
    input  logic [2:0]        src0_hsize,
    input  logic [2:0]        src0_hburst,
    input  logic [3:0]        src0_hprot,
    input  logic              src0_hmastlock,
    input  logic [W_DATA-1:0] src0_hwdata,
    output logic [W_DATA-1:0] src0_hrdata,
    output logic              src1_hready_resp,
    input  logic              src1_hready,
    output logic              src1_hresp,
    input  logic [W_ADDR-1:0] src1_haddr,
    input  logic              src1_hwrite,
    input  logic [1:0]        src1_htrans,
    input  logic [2:0]        src1_hsize,
    input  logic [2:0]        src1_hburst,
    input  logic [3:0]        src1_hprot,
    input  logic              src1_hmastlock,
    input  logic [W_DATA-1:0] src1_hwdata,
    output logic [W_DATA-1:0] src1_hrdata,
    input  logic              dst_hready_resp,
    output logic              dst_hready,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    typedef enum logic [1:0] {IDLE, PEND, DPH} port_state_t;

    typedef struct packed {
        logic [W_ADDR-1:0] haddr;
        logic              hwrite;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } addr_ph_t;

    addr_ph_t    req [2];
    addr_ph_t    buf_q [2];
    addr_ph_t    hold_q;
    addr_ph_t    dst_ph;
    port_state_t state_q [2];
    logic [1:0]  live;
    logic [1:0]  cand;
    logic [1:0]  win;
    logic [1:0]  rdy_resp;
    logic [1:0]  err_resp;
    logic        slot;
    logic        gnt_vld;
    logic        gnt_id;
    logic        own_vld;
    logic        own_id;
    logic        lock_vld;
    logic        lock_id;

    assign req[0] = '{haddr: src0_haddr, hwrite: src0_hwrite, htrans: src0_htrans,
                      hsize: src0_hsize, hburst: src0_hburst, hprot: src0_hprot,
                      hmastlock: src0_hmastlock};
    assign req[1] = '{haddr: src1_haddr, hwrite: src1_hwrite, htrans: src1_htrans,
                      hsize: src1_hsize, hburst: src1_hburst, hprot: src1_hprot,
                      hmastlock: src1_hmastlock};

    // Gating with rst_n keeps dst_htrans at IDLE while reset is held.
    assign live[0] = rst_n && src0_htrans[1] && src0_hready;
    assign live[1] = rst_n && src1_htrans[1] && src1_hready;
    assign slot    = rst_n && dst_hready_resp;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            cand[n]     = (state_q[n] == PEND) || live[n];
            rdy_resp[n] = (state_q[n] == PEND) ? 1'b0 :
                          (state_q[n] == DPH)  ? dst_hready_resp : 1'b1;
            err_resp[n] = (state_q[n] == DPH) && dst_hresp;
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (slot) begin
            if (lock_vld) begin
                gnt_vld = cand[lock_id];
                gnt_id  = lock_id;
            end else if (cand[0]) begin
                gnt_vld = 1'b1;
            end else if (cand[1]) begin
                gnt_vld = 1'b1;
                gnt_id  = 1'b1;
            end
        end
        win = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    end

    // Outside an issue slot the subordinate ignores the address bus, so hold it.
    always_comb begin
        dst_ph = hold_q;
        if (slot) begin
            if (gnt_vld)
                dst_ph = (state_q[gnt_id] == PEND) ? buf_q[gnt_id] : req[gnt_id];
            else
                dst_ph.htrans = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= '{IDLE, IDLE};
            hold_q   <= '0;
            own_vld  <= 1'b0;
            own_id   <= 1'b0;
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
        end else begin
            if (slot) begin
                hold_q  <= dst_ph;
                own_vld <= gnt_vld;
                own_id  <= gnt_id;
                if (gnt_vld) begin
                    if (dst_ph.hmastlock) begin
                        lock_vld <= 1'b1;
                        lock_id  <= gnt_id;
                    end else if (lock_vld && lock_id == gnt_id) begin
                        lock_vld <= 1'b0;
                    end
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (win[n])
                    state_q[n] <= DPH;
                else if (live[n])
                    state_q[n] <= PEND;
                else if (state_q[n] == DPH && dst_hready_resp)
                    state_q[n] <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++)
            if (live[n] && !win[n])
                buf_q[n] <= req[n];
    end

    assign src0_hready_resp = rdy_resp[0];
    assign src1_hready_resp = rdy_resp[1];
    assign src0_hresp       = err_resp[0];
    assign src1_hresp       = err_resp[1];
    assign src0_hrdata      = dst_hrdata;
    assign src1_hrdata      = dst_hrdata;
    assign dst_hready       = dst_hready_resp;
    assign dst_haddr        = dst_ph.haddr;
    assign dst_hwrite       = dst_ph.hwrite;
    assign dst_htrans       = dst_ph.htrans;
    assign dst_hsize        = dst_ph.hsize;
    assign dst_hburst       = dst_ph.hburst;
    assign dst_hprot        = dst_ph.hprot;
    assign dst_hmastlock    = dst_ph.hmastlock;
    assign dst_hwdata       = own_vld ? (own_id ? src1_hwdata : src0_hwdata) : '0;

endmodule
